tt_board_adapter: RTL and testbench

// - Parametrised FPGA-board adapter around a TinyTapeout project; next generation of the fixed halve-clock pad wrapper.
// - Derives project clock (divide by CLK_DIV) and a stretched, edge-aligned project reset.
// - Synchronises all pad inputs; registers pad outputs.
// - Drives bidir pads with per-bit contention-free OE turnaround. Sits between board top level and the tt_um_* instance.

---
 rtl/tt_board_pkg.sv | 19 +
 rtl/tt_pad_sync.sv | 30 +++
 rtl/tt_board_adapter.sv | 121 ++++++++++++
 tb/tb_tt_board_adapter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tt_board_pkg.sv
// Shared widths, counter sizing helper and elaboration parameter check for
// the TinyTapeout board adapter.
package tt_board_pkg;

    localparam int unsigned TT_UI_W  = 8;
    localparam int unsigned TT_UO_W  = 8;
    localparam int unsigned TT_UIO_W = 8;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`ifndef TT_PARAM_CHECK
// Stops elaboration when a parameter combination is unusable.
`define TT_PARAM_CHECK(cond, msg) initial begin if (!(cond)) $fatal(1, msg); end
`endif

// File: rtl/tt_pad_sync.sv
// Multi-stage reset-to-0 input synchroniser.
// Ports: clk, rst_n (sync, active-low), d (async pad input), q (d delayed
// by exactly STAGES clk cycles).
module tt_pad_sync
    import tt_board_pkg::*;
#(
    parameter int unsigned W      = TT_UI_W,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    // Shift chain; stage 0 is the only flop that sees the raw pad.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) stage[k] <= '0;
        end else begin
            stage[0] <= d;
            for (int k = 1; k < int'(STAGES); k++) stage[k] <= stage[k-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/tt_board_adapter.sv
// FPGA-board adapter around a TinyTapeout project: divided project clock,
// stretched project reset aligned to a proj_clk fall, synchronised pad
// inputs, registered pad outputs and bidir pads with OE turnaround.
// Ports: clk/rst_n board clock and sync active-low reset; ui_pad/uo_pad/
// uio_pad board pads; proj_clk, proj_rst_n, proj_clk_rise project timing;
// proj_ui_in/proj_uio_in synchronised inputs; proj_uo_out, proj_uio_out,
// proj_uio_oe project outputs and bidir enables (1 = drive).
module tt_board_adapter
    import tt_board_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned RST_HOLD_CYCLES = 4,
    parameter int unsigned OE_TURN_CYCLES  = 2,
    parameter int unsigned UI_W            = TT_UI_W,
    parameter int unsigned UO_W            = TT_UO_W,
    parameter int unsigned UIO_W           = TT_UIO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [UI_W-1:0]  ui_pad,
    output logic [UO_W-1:0]  uo_pad,
    inout  wire  [UIO_W-1:0] uio_pad,
    output logic             proj_clk,
    output logic             proj_rst_n,
    output logic             proj_clk_rise,
    output logic [UI_W-1:0]  proj_ui_in,
    input  logic [UO_W-1:0]  proj_uo_out,
    output logic [UIO_W-1:0] proj_uio_in,
    input  logic [UIO_W-1:0] proj_uio_out,
    input  logic [UIO_W-1:0] proj_uio_oe
);

    `TT_PARAM_CHECK((CLK_DIV >= 2) && (CLK_DIV % 2 == 0), "CLK_DIV must be even and >= 2")
    `TT_PARAM_CHECK(SYNC_STAGES >= 2, "SYNC_STAGES must be >= 2")
    `TT_PARAM_CHECK(RST_HOLD_CYCLES >= 1, "RST_HOLD_CYCLES must be >= 1")

    localparam int unsigned HALF    = CLK_DIV / 2;
    localparam int unsigned DIV_MAX = HALF - 1;
    localparam int unsigned DIV_W   = cnt_w(DIV_MAX);
    localparam int unsigned HOLD_W  = cnt_w(RST_HOLD_CYCLES);
    localparam int unsigned TURN_W  = cnt_w(OE_TURN_CYCLES);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(OE_TURN_CYCLES);

    logic [DIV_W-1:0]  div_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              wrap;
    logic [UIO_W-1:0]  oe_q;
    logic [UIO_W-1:0]  dat_q;

    // Wrap marks the last clk of each proj_clk half period; decoded from flops.
    always_comb begin
        wrap          = (div_cnt == DIV_LAST);
        proj_clk_rise = wrap & ~proj_clk;
    end

    // Divider plus reset stretch: count proj_clk rises, release on a fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            proj_clk   <= 1'b0;
            hold_cnt   <= '0;
            proj_rst_n <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
            if (wrap) proj_clk <= ~proj_clk;
            if (proj_clk_rise && (hold_cnt != HOLD_LAST)) hold_cnt <= hold_cnt + HOLD_W'(1);
            if (wrap && proj_clk && (hold_cnt == HOLD_LAST)) proj_rst_n <= 1'b1;
        end
    end

    // Output pad and bidir request registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_pad <= '0;
            oe_q   <= '0;
            dat_q  <= '0;
        end else begin
            uo_pad <= proj_uo_out;
            oe_q   <= proj_uio_oe;
            dat_q  <= proj_uio_out;
        end
    end

    // Per-bit turnaround: drive only after OE has been held for the full
    // count; gating with oe_q makes release take effect the same cycle.
    for (genvar i = 0; i < int'(UIO_W); i++) begin : g_uio
        logic [TURN_W-1:0] turn_cnt;
        logic              drive;

        always_ff @(posedge clk) begin
            if (!rst_n || !oe_q[i]) begin
                turn_cnt <= '0;
            end else if (turn_cnt != TURN_LAST) begin
                turn_cnt <= turn_cnt + TURN_W'(1);
            end
        end

        assign drive      = oe_q[i] && (turn_cnt == TURN_LAST);
        assign uio_pad[i] = drive ? dat_q[i] : 1'bz;
    end

    tt_pad_sync #(.W(UI_W), .STAGES(SYNC_STAGES)) u_ui_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_pad),
        .q     (proj_ui_in)
    );

    // Readback path: sampled even while the adapter drives the bit.
    tt_pad_sync #(.W(UIO_W), .STAGES(SYNC_STAGES)) u_uio_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_pad),
        .q     (proj_uio_in)
    );

endmodule

// File: tb/tb_tt_board_adapter.sv
// Randomised scoreboard bench for tt_board_adapter. Every edge's inputs are
// logged; expected outputs are derived from that history with the adapter's
// timing rules (edges since release, OE-held windows, sync latency).
module tb_tt_board_adapter;

    localparam int CLK_DIV = 6;
    localparam int SYNC    = 3;
    localparam int HOLD    = 4;
    localparam int TURN    = 2;
    localparam int HALF    = CLK_DIV / 2;
    localparam int NCYC    = 900;

    typedef struct {
        bit         rst;
        logic [7:0] ui, uo, oe, dat, ext_en, ext_val;
    } in_t;

    typedef struct {
        int         tag;
        logic [7:0] uo, ui_in, uio_in, pad;
        logic       pclk, prst, rise;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_pad, proj_uo_out, proj_uio_out, proj_uio_oe;
    logic [7:0] ext_en, ext_val;
    wire  [7:0] uio_pad;
    logic [7:0] uo_pad, proj_ui_in, proj_uio_in;
    logic       proj_clk, proj_rst_n, proj_clk_rise;

    in_t  hist[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Board-side pad: optional external drive, weak pull-up when released.
    for (genvar g = 0; g < 8; g++) begin : g_pad
        assign uio_pad[g] = ext_en[g] ? ext_val[g] : 1'bz;
        pullup pu (uio_pad[g]);
    end

    tt_board_adapter #(
        .CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC), .RST_HOLD_CYCLES(HOLD),
        .OE_TURN_CYCLES(TURN), .UI_W(8), .UO_W(8), .UIO_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ui_pad(ui_pad), .uo_pad(uo_pad), .uio_pad(uio_pad),
        .proj_clk(proj_clk), .proj_rst_n(proj_rst_n), .proj_clk_rise(proj_clk_rise),
        .proj_ui_in(proj_ui_in), .proj_uo_out(proj_uo_out), .proj_uio_in(proj_uio_in),
        .proj_uio_out(proj_uio_out), .proj_uio_oe(proj_uio_oe)
    );

    // ---------------- reference model over the input history ----------------
    function automatic in_t h(input int k);
        in_t r;
        r.rst = 1'b0; r.ui = '0; r.uo = '0; r.oe = '0; r.dat = '0; r.ext_en = '0; r.ext_val = '0;
        if (k >= 0 && k < hist.size()) r = hist[k];
        return r;
    endfunction

    // Consecutive edges with reset released, ending at edge n.
    function automatic int since(input int n);
        int c = 0;
        for (int k = n; k >= 0; k--) begin
            if (!h(k).rst) break;
            c++;
        end
        return c;
    endfunction

    // Bit i driven after edge n: OE requested on the last TURN+1 edges, none in reset.
    function automatic bit drv(input int n, input int i);
        if (n < 0 || since(n) < TURN + 1) return 1'b0;
        for (int k = n - TURN; k <= n; k++) if (!h(k).oe[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Pad level seen between edge m-1 and edge m.
    function automatic logic padbit(input int m, input int i);
        if (drv(m - 1, i)) return h(m - 1).dat[i];
        if (h(m).ext_en[i]) return h(m).ext_val[i];
        return 1'b1;
    endfunction

    function automatic logic [7:0] sync_exp(input int n, input bit is_uio);
        logic [7:0] v;
        int m = n - SYNC + 1;
        for (int k = m; k <= n; k++) if (!h(k).rst) return 8'h00;
        if (!is_uio) return h(m).ui;
        for (int i = 0; i < 8; i++) v[i] = padbit(m, i);
        return v;
    endfunction

    function automatic exp_t model(input int n);
        exp_t e;
        int   s = since(n);
        e.tag    = n;
        e.uo     = h(n).rst ? h(n).uo : 8'h00;
        e.pclk   = ((s / HALF) % 2) == 1;
        e.prst   = s >= 2 * HALF * HOLD;
        e.rise   = ((s + 1) % (2 * HALF)) == HALF;
        e.ui_in  = sync_exp(n, 1'b0);
        e.uio_in = sync_exp(n, 1'b1);
        e.pad    = padbit(n + 1, 0) ? 8'h01 : 8'h00;
        for (int i = 0; i < 8; i++) e.pad[i] = padbit(n + 1, i);
        return e;
    endfunction

    task automatic check(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s edge=%0d got=%02h expected=%02h", name, tag, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         oe_left = 0;
        logic [7:0] oe_cur  = '0;
        logic [7:0] allow;
        in_t        e;
        rst_n = 1'b0; ui_pad = '0; proj_uo_out = '0; proj_uio_out = '0;
        proj_uio_oe = '0; ext_en = '0; ext_val = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            // Reset at start, a mid-run reset under full OE, and a short one later.
            e.rst = !(cyc < 4 || (cyc >= 300 && cyc < 303) || (cyc >= 600 && cyc < 602));
            if (oe_left == 0) begin
                case ($urandom_range(3))
                    0: oe_cur = 8'h00;
                    1: oe_cur = 8'h0F;
                    2: oe_cur = 8'hFF;
                    default: oe_cur = 8'($urandom);
                endcase
                oe_left = $urandom_range(8, 1);
            end
            oe_left--;
            e.oe  = (cyc >= 285 && cyc < 306) ? 8'hFF : oe_cur;
            e.ui  = (cyc == 150) ? 8'hA5 : (cyc > 140 && cyc < 150) ? 8'h00 :
                    ($urandom_range(1) != 0) ? 8'($urandom) : h(cyc - 1).ui;
            e.uo  = 8'($urandom);
            e.dat = ($urandom_range(1) != 0) ? 8'($urandom) : h(cyc - 1).dat;
            // External drive only on bits the adapter cannot drive around this edge.
            allow = '0;
            for (int i = 0; i < 8; i++) allow[i] = !drv(cyc - 1, i) && !e.oe[i];
            e.ext_en  = (cyc >= 400 && cyc < 420) ? allow : allow & 8'($urandom);
            e.ext_val = (cyc >= 400 && cyc < 420) ? 8'h3C : 8'($urandom);
            rst_n = e.rst; ui_pad = e.ui; proj_uo_out = e.uo; proj_uio_oe = e.oe;
            proj_uio_out = e.dat; ext_en = e.ext_en; ext_val = e.ext_val;
            hist.push_back(e);
            if (cyc >= 1) sb.push_back(model(cyc - 1));
            @(posedge clk);
            #1;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t x;
        for (int n = 0; n < NCYC - 1; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (sb.size() == 0 || sb[0].tag != n) begin
                checks++;
                failures++;
                $display("FAIL scoreboard edge=%0d got=no_entry expected=entry", n);
            end else begin
                x = sb.pop_front();
                check("uo_pad",        n, uo_pad,                  x.uo);
                check("proj_clk",      n, {7'd0, proj_clk},        {7'd0, x.pclk});
                check("proj_rst_n",    n, {7'd0, proj_rst_n},      {7'd0, x.prst});
                check("proj_clk_rise", n, {7'd0, proj_clk_rise},   {7'd0, x.rise});
                check("proj_ui_in",    n, proj_ui_in,              x.ui_in);
                check("proj_uio_in",   n, proj_uio_in,             x.uio_in);
                check("uio_pad",       n, uio_pad,                 x.pad);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
